// File: rtl/result_reorder_buffer.sv
// Completion reorder buffer: captures tagged results in per-tag slots and
// retires them strictly in ascending tag order through a valid/ready port.
module result_reorder_buffer #(
    parameter int TAG_W = 3,
    parameter int RES_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [RES_W-1:0] in_result,
    input  logic [TAG_W-1:0] in_rtag,
    input  logic             in_error,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [RES_W-1:0] out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_error,
    output logic [TAG_W:0]   occupancy,
    output logic             dup_error
);

    localparam int DEPTH = 2 ** TAG_W;
    localparam logic [TAG_W-1:0] HEAD_ONE = {{(TAG_W-1){1'b0}}, 1'b1};
    localparam logic [TAG_W:0]   OCC_ONE  = {{TAG_W{1'b0}}, 1'b1};

    logic [DEPTH-1:0] full_q, full_d;
    logic [RES_W-1:0] res_q [DEPTH];
    logic [RES_W-1:0] res_d [DEPTH];
    logic [DEPTH-1:0] err_q, err_d;
    logic [TAG_W-1:0] head_q, head_d;
    logic [TAG_W:0]   occ_q, occ_d;
    logic             dup_q, dup_d;

    logic wr_s;
    logic rt_s;

    // Duplicate detection looks at the full bit before any same-cycle retire.
    always_comb begin
        wr_s  = in_valid & ~full_q[in_rtag];
        dup_d = in_valid & full_q[in_rtag];
        rt_s  = full_q[head_q] & out_ready;
    end

    // Next-state for slot storage, head pointer and occupancy.
    always_comb begin
        full_d = full_q;
        err_d  = err_q;
        res_d  = res_q;
        head_d = head_q;
        occ_d  = occ_q;
        if (wr_s) begin
            full_d[in_rtag] = 1'b1;
            res_d[in_rtag]  = in_result;
            err_d[in_rtag]  = in_error;
        end else begin
            full_d[in_rtag] = full_q[in_rtag];
        end
        if (rt_s) begin
            full_d[head_q] = 1'b0;
            head_d         = head_q + HEAD_ONE;
        end else begin
            head_d = head_q;
        end
        if (wr_s && !rt_s) begin
            occ_d = occ_q + OCC_ONE;
        end else if (rt_s && !wr_s) begin
            occ_d = occ_q - OCC_ONE;
        end else begin
            occ_d = occ_q;
        end
    end

    // State registers; reset also clears slot data so the head port reads zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            full_q <= {DEPTH{1'b0}};
            err_q  <= {DEPTH{1'b0}};
            head_q <= {TAG_W{1'b0}};
            occ_q  <= {(TAG_W+1){1'b0}};
            dup_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                res_q[i] <= {RES_W{1'b0}};
            end
        end else begin
            full_q <= full_d;
            err_q  <= err_d;
            head_q <= head_d;
            occ_q  <= occ_d;
            dup_q  <= dup_d;
            for (int i = 0; i < DEPTH; i++) begin
                res_q[i] <= res_d[i];
            end
        end
    end

    // Output port reads only registered state.
    always_comb begin
        out_valid  = full_q[head_q];
        out_result = res_q[head_q];
        out_error  = err_q[head_q];
        out_tag    = head_q;
        occupancy  = occ_q;
        dup_error  = dup_q;
    end

endmodule

// File: tb/tb_result_reorder_buffer.sv
// Directed, table-driven bench for result_reorder_buffer with hand-computed
// expectations sampled 1 time unit after each rising edge.
module tb_result_reorder_buffer;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_result;
    logic [2:0]  in_rtag;
    logic        in_error;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] out_result;
    logic [2:0]  out_tag;
    logic        out_error;
    logic [3:0]  occupancy;
    logic        dup_error;

    int checks;
    int errors;

    typedef struct {
        logic        rst;
        logic        vld;
        logic [2:0]  tag;
        logic [31:0] res;
        logic        err;
        logic        rdy;
        logic        e_valid;
        logic [2:0]  e_tag;
        logic [31:0] e_res;
        logic        e_err;
        logic [3:0]  e_occ;
        logic        e_dup;
        logic        chk_d;
    } vec_t;

    vec_t tbl[$];

    result_reorder_buffer #(.TAG_W(3), .RES_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_result  (in_result),
        .in_rtag    (in_rtag),
        .in_error   (in_error),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_result (out_result),
        .out_tag    (out_tag),
        .out_error  (out_error),
        .occupancy  (occupancy),
        .dup_error  (dup_error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic add(input logic rst, input logic vld, input logic [2:0] tag,
                       input logic [31:0] res, input logic err, input logic rdy,
                       input logic e_valid, input logic [2:0] e_tag,
                       input logic [31:0] e_res, input logic e_err,
                       input logic [3:0] e_occ, input logic e_dup, input logic chk_d);
        vec_t v;
        v.rst = rst; v.vld = vld; v.tag = tag; v.res = res; v.err = err; v.rdy = rdy;
        v.e_valid = e_valid; v.e_tag = e_tag; v.e_res = e_res; v.e_err = e_err;
        v.e_occ = e_occ; v.e_dup = e_dup; v.chk_d = chk_d;
        tbl.push_back(v);
    endtask

    task automatic add_reset();
        add(1'b1, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0,
            1'b0, 3'd0, 32'h0, 1'b0, 4'd0, 1'b0, 1'b1);
    endtask

    task automatic add_idle(input logic rdy, input logic e_valid, input logic [2:0] e_tag,
                            input logic [31:0] e_res, input logic e_err,
                            input logic [3:0] e_occ, input logic e_dup, input logic chk_d);
        add(1'b0, 1'b0, 3'd0, 32'h0, 1'b0, rdy, e_valid, e_tag, e_res, e_err, e_occ, e_dup, chk_d);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
        end
    endtask

    initial begin
        logic [2:0]  t3;
        logic [31:0] r32;
        logic [3:0]  o4;
        logic        b;

        checks = 0;
        errors = 0;
        reset = 1'b1; in_valid = 1'b0; in_result = 32'h0;
        in_rtag = 3'd0; in_error = 1'b0; out_ready = 1'b0;

        // Reset state
        add_reset();
        add_reset();
        // Single in-order write, retired immediately
        add(1'b0, 1'b1, 3'd0, 32'h0000_00A5, 1'b0, 1'b1, 1'b1, 3'd0, 32'h0000_00A5, 1'b0, 4'd1, 1'b0, 1'b1);
        add_idle(1'b1, 1'b0, 3'd1, 32'h0, 1'b0, 4'd0, 1'b0, 1'b0);
        // Out-of-order 2,1,0 then in-order retirement
        add_reset();
        add(1'b0, 1'b1, 3'd2, 32'h22, 1'b0, 1'b1, 1'b0, 3'd0, 32'h0, 1'b0, 4'd1, 1'b0, 1'b0);
        add(1'b0, 1'b1, 3'd1, 32'h11, 1'b0, 1'b1, 1'b0, 3'd0, 32'h0, 1'b0, 4'd2, 1'b0, 1'b0);
        add(1'b0, 1'b1, 3'd0, 32'h00, 1'b0, 1'b1, 1'b1, 3'd0, 32'h00, 1'b0, 4'd3, 1'b0, 1'b1);
        add_idle(1'b1, 1'b1, 3'd1, 32'h11, 1'b0, 4'd2, 1'b0, 1'b1);
        add_idle(1'b1, 1'b1, 3'd2, 32'h22, 1'b0, 4'd1, 1'b0, 1'b1);
        add_idle(1'b1, 1'b0, 3'd3, 32'h0, 1'b0, 4'd0, 1'b0, 1'b0);
        // Backpressure: fill all eight slots, head output held on tag 0
        add_reset();
        for (int i = 0; i < 8; i++) begin
            t3 = 3'(i); r32 = 32'h10 + 32'(i); b = t3[0]; o4 = 4'(i + 1);
            add(1'b0, 1'b1, t3, r32, b, 1'b0, 1'b1, 3'd0, 32'h10, 1'b0, o4, 1'b0, 1'b1);
        end
        for (int k = 1; k <= 8; k++) begin
            t3 = 3'(k % 8); r32 = 32'h10 + 32'(k % 8); b = t3[0]; o4 = 4'(8 - k);
            add_idle(1'b1, (k < 8), t3, r32, b, o4, 1'b0, (k < 8));
        end
        add(1'b0, 1'b1, 3'd0, 32'h55, 1'b0, 1'b1, 1'b1, 3'd0, 32'h55, 1'b0, 4'd1, 1'b0, 1'b1);
        add_idle(1'b1, 1'b0, 3'd1, 32'h0, 1'b0, 4'd0, 1'b0, 1'b0);
        // Duplicate write to tag 3 keeps the first result
        add(1'b0, 1'b1, 3'd3, 32'h33, 1'b0, 1'b0, 1'b0, 3'd1, 32'h0, 1'b0, 4'd1, 1'b0, 1'b0);
        add(1'b0, 1'b1, 3'd3, 32'h44, 1'b0, 1'b0, 1'b0, 3'd1, 32'h0, 1'b0, 4'd1, 1'b1, 1'b0);
        add(1'b0, 1'b1, 3'd1, 32'h01, 1'b0, 1'b0, 1'b1, 3'd1, 32'h01, 1'b0, 4'd2, 1'b0, 1'b1);
        add(1'b0, 1'b1, 3'd2, 32'h02, 1'b0, 1'b0, 1'b1, 3'd1, 32'h01, 1'b0, 4'd3, 1'b0, 1'b1);
        add_idle(1'b1, 1'b1, 3'd2, 32'h02, 1'b0, 4'd2, 1'b0, 1'b1);
        add_idle(1'b1, 1'b1, 3'd3, 32'h33, 1'b0, 4'd1, 1'b0, 1'b1);
        add_idle(1'b1, 1'b0, 3'd4, 32'h0, 1'b0, 4'd0, 1'b0, 1'b0);
        // Duplicate hitting the slot that retires in the same cycle
        add(1'b0, 1'b1, 3'd4, 32'h40, 1'b1, 1'b0, 1'b1, 3'd4, 32'h40, 1'b1, 4'd1, 1'b0, 1'b1);
        add(1'b0, 1'b1, 3'd4, 32'h99, 1'b0, 1'b1, 1'b0, 3'd5, 32'h0, 1'b0, 4'd0, 1'b1, 1'b0);
        add_idle(1'b0, 1'b0, 3'd5, 32'h0, 1'b0, 4'd0, 1'b0, 1'b0);
        // Simultaneous retire of head 0 and write of tag 5
        add_reset();
        add(1'b0, 1'b1, 3'd0, 32'h0A, 1'b0, 1'b0, 1'b1, 3'd0, 32'h0A, 1'b0, 4'd1, 1'b0, 1'b1);
        add(1'b0, 1'b1, 3'd5, 32'h5A, 1'b0, 1'b1, 1'b0, 3'd1, 32'h0, 1'b0, 4'd1, 1'b0, 1'b0);
        // Reset mid-stream wins over a same-cycle write
        add_reset();
        for (int i = 0; i < 4; i++) begin
            t3 = 3'(i); r32 = 32'(i); o4 = 4'(i + 1);
            add(1'b0, 1'b1, t3, r32, 1'b0, 1'b0, 1'b1, 3'd0, 32'h0, 1'b0, o4, 1'b0, 1'b1);
        end
        add(1'b1, 1'b1, 3'd4, 32'h44, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 4'd0, 1'b0, 1'b1);
        add(1'b0, 1'b1, 3'd4, 32'h77, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 4'd1, 1'b0, 1'b1);
        add_idle(1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 4'd1, 1'b0, 1'b1);

        foreach (tbl[i]) begin
            reset     = tbl[i].rst;
            in_valid  = tbl[i].vld;
            in_rtag   = tbl[i].tag;
            in_result = tbl[i].res;
            in_error  = tbl[i].err;
            out_ready = tbl[i].rdy;
            @(posedge clk);
            #1;
            check($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(tbl[i].e_valid));
            check($sformatf("v%0d out_tag", i), 32'(out_tag), 32'(tbl[i].e_tag));
            check($sformatf("v%0d occupancy", i), 32'(occupancy), 32'(tbl[i].e_occ));
            check($sformatf("v%0d dup_error", i), 32'(dup_error), 32'(tbl[i].e_dup));
            if (tbl[i].chk_d) begin
                check($sformatf("v%0d out_result", i), out_result, tbl[i].e_res);
                check($sformatf("v%0d out_error", i), 32'(out_error), 32'(tbl[i].e_err));
            end
        end

        // Inputs change between edges: outputs must not follow combinationally
        in_valid = 1'b1; in_rtag = 3'd0; in_result = 32'hDEAD; in_error = 1'b1; out_ready = 1'b1;
        #2;
        check("comb out_valid", 32'(out_valid), 32'h0);
        check("comb out_result", out_result, 32'h0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("late out_valid", 32'(out_valid), 32'h1);
        check("late out_result", out_result, 32'hDEAD);
        check("late out_error", 32'(out_error), 32'h1);
        check("late occupancy", 32'(occupancy), 32'h2);
        @(posedge clk);
        #1;
        check("final out_tag", 32'(out_tag), 32'h1);
        check("final occupancy", 32'(occupancy), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
